fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage of the 16-bit pipelined core: owns the architectural PC and the IF/ID pipeline register, and issues requests to the instruction cache. It is the consuming end of the branch-resolution path: it receives the taken-branch redirect and target produced in decode, squashes wrong-path fetches, honours hazard stalls, and stops fetching at HLT. Sits between the I-cache/memory interface and the decode stage.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset.
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- redirect_valid  in  1  taken branch resolved in ID this cycle.
- redirect_addr  in  16  branch target; valid when redirect_valid=1.
- hazard_stall  in  1  ID cannot accept a new instruction; hold PC and IF/ID.
- icache_req  out  1  fetch request to I-cache.
- icache_addr  out  16  fetch address (current PC).
- icache_ready  in  1  icache_data valid for icache_addr this cycle (same cycle on hit, later on miss).
- icache_data  in  16  fetched instruction word.
- if_valid  out  1  IF/ID holds a real instruction.
- if_instr  out  16  IF/ID instruction; FETCH_NOP when if_valid=0.
- if_pc  out  16  IF/ID instruction address.
- if_pc_plus2  out  16  if_pc + 2 (mod 2^16).
- fetch_halted  out  1  fetch stopped after delivering HLT.

## Operation
- States: RUN, SQUASH, HALTED. Registers: pc, pending_target, IF/ID fields.
- icache_req=1 in RUN and SQUASH, 0 in HALTED and while rst_n=0. icache_addr=pc in RUN/SQUASH; held stable until icache_ready.
- Per-cycle priority: rst_n=0 > redirect_valid > hazard_stall > normal fetch.
- RUN, redirect_valid=1, icache_ready=1: pc<=redirect_addr, IF/ID<=bubble, fetched word discarded, stay RUN.
- RUN, redirect_valid=1, icache_ready=0: miss in flight; pending_target<=redirect_addr, IF/ID<=bubble, go SQUASH.
- RUN, hazard_stall=1 (no redirect): pc and IF/ID hold; request remains asserted.
- RUN, icache_ready=0 (no redirect/stall): IF/ID<=bubble, pc holds.
- RUN, icache_ready=1, normal: IF/ID<={1, icache_data, pc, pc+2}; if icache_data[15:12]==HALT_OP then pc holds and go HALTED, else pc<=pc+2.
- SQUASH: icache_ready=1 -> data discarded, pc<=pending_target, IF/ID bubble, go RUN. redirect_valid in SQUASH overwrites pending_target (newest wins). hazard_stall ignored for the discarded data.
- HALTED: fetch_halted=1; pc holds HLT address. IF/ID: hazard_stall holds it, else bubble. redirect_valid=1 (older branch in ID overriding HLT) -> pc<=redirect_addr, IF/ID bubble, go RUN.
- HLT fetched in same cycle as redirect_valid: redirect wins, HLT discarded, no HALTED entry.
- PC arithmetic modulo 2^16; 16'hFFFE+2 wraps to 16'h0000.

## Timing
- Reset (rst_n low at edge): pc=RESET_PC, state RUN, pending_target=0, if_valid=0, if_instr=FETCH_NOP, if_pc=0, if_pc_plus2=0, fetch_halted=0, icache_req=0 while rst_n=0.
- Hit: request cycle N with ready=1 -> instruction in IF/ID after edge N; next fetch address in cycle N+1. Sustained throughput 1 instr/cycle.
- Miss of k cycles: k bubbles into IF/ID, instruction loaded at edge of ready cycle.
- Redirect latency: target presented on icache_addr cycle after redirect (RUN), or cycle after miss completes (SQUASH). One bubble minimum per taken branch.
- Reset asserted mid-miss or in SQUASH: state cleared; stale icache_ready after reset is ignored until RUN request issued.

## Structure
- Package fetch_pkg: state enum (RUN, SQUASH, HALTED), HALT_OP=4'hF, FETCH_NOP=16'h0000.
- PC+2 computed with the existing cla_16bit adder (Cin=0, carry/overflow unused); no other sub-modules.

## Test plan
- Reset then hits every cycle from 0x0000 -> if_pc sequence 0x0000, 0x0002, 0x0004, if_valid=1 each cycle after first fetch.
- Miss of 3 cycles at 0x0010 -> 3 bubbles, then if_instr=icache_data, if_pc=0x0010, pc advances to 0x0012.
- redirect_valid with target 0x0100 during hit at 0x0020 -> IF/ID bubble, next icache_addr=0x0100.
- redirect to 0x0200 during 4-cycle miss at 0x0030, second redirect to 0x0300 in SQUASH -> miss data discarded, next icache_addr=0x0300.
- HLT (0xF000) fetched at 0x0040 -> if_instr=0xF000, fetch_halted=1, icache_req=0, pc stays 0x0040; later redirect to 0x0050 resumes fetch.
- hazard_stall for 2 cycles on hit at 0x0060 -> IF/ID and pc unchanged 2 cycles; HLT and redirect in same cycle -> no halt.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction-fetch stage.
//                Holds the fetch FSM state type, the HLT opcode, the bubble
//                encoding placed in IF/ID, and a small opcode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Fetch sequencer states.
  //   RUN    : normal fetching from the current PC
  //   SQUASH : a wrong-path miss is still outstanding; its data is dropped
  //   HALTED : HLT was delivered to decode, no further requests issued
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SQUASH = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  localparam logic [3:0]  HALT_OP   = 4'hF;
  localparam logic [15:0] FETCH_NOP = 16'h0000;
  localparam logic [15:0] PC_STEP   = 16'h0002;

  // True when the instruction word carries the HLT opcode.
  function automatic logic is_halt(input logic [15:0] instr);
    return (instr[15:12] == HALT_OP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cla_16bit.sv
`default_nettype none
// ============================================================================
//  Module      : cla_16bit
//  Description : 16-bit two-level carry-lookahead adder built from four 4-bit
//                lookahead groups joined by a group-level lookahead unit.
//  Ports       : a, b      - addends
//                cin       - carry in
//                sum       - a + b + cin (mod 2^16)
//                cout      - carry out of bit 15
//                overflow  - signed (two's complement) overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout,
  output logic        overflow
);

  logic [15:0] gen;
  logic [15:0] prop;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [3:0]  grp_cin;

  assign gen  = a & b;
  assign prop = a ^ b;

  // Group carries are expanded directly from cin so no carry depends on
  // another bit of the same vector.
  assign grp_cin[0] = cin;
  assign grp_cin[1] = grp_g[0] | (grp_p[0] & cin);
  assign grp_cin[2] = grp_g[1] | (grp_p[1] & grp_g[0])
                    | (grp_p[1] & grp_p[0] & cin);
  assign grp_cin[3] = grp_g[2] | (grp_p[2] & grp_g[1])
                    | (grp_p[2] & grp_p[1] & grp_g[0])
                    | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
  assign cout       = grp_g[3] | (grp_p[3] & grp_g[2])
                    | (grp_p[3] & grp_p[2] & grp_g[1])
                    | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                    | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin);

  generate
    for (genvar i = 0; i < 4; i++) begin : g_group
      logic [3:0] gl;
      logic [3:0] pl;
      logic       c0;
      logic       c1;
      logic       c2;
      logic       c3;

      assign gl = gen[4*i +: 4];
      assign pl = prop[4*i +: 4];
      assign c0 = grp_cin[i];
      assign c1 = gl[0] | (pl[0] & c0);
      assign c2 = gl[1] | (pl[1] & gl[0]) | (pl[1] & pl[0] & c0);
      assign c3 = gl[2] | (pl[2] & gl[1]) | (pl[2] & pl[1] & gl[0])
                | (pl[2] & pl[1] & pl[0] & c0);

      assign grp_g[i] = gl[3] | (pl[3] & gl[2]) | (pl[3] & pl[2] & gl[1])
                      | (pl[3] & pl[2] & pl[1] & gl[0]);
      assign grp_p[i] = &pl;

      assign sum[4*i +: 4] = pl ^ {c3, c2, c1, c0};
    end
  endgenerate

  // Carry into bit 15 is recovered from that bit's sum, avoiding a tap into
  // the last group.
  assign overflow = (a[15] ^ b[15] ^ sum[15]) ^ cout;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Owns the architectural PC and the
//                IF/ID pipeline register, issues I-cache requests, applies
//                taken-branch redirects from decode (squashing wrong-path
//                fetches, including misses still in flight), honours hazard
//                stalls and stops fetching once HLT has been delivered.
//  Ports       : clk, rst_n          - clock, synchronous active-low reset
//                redirect_valid/addr - taken branch from ID and its target
//                hazard_stall        - ID cannot accept; hold PC and IF/ID
//                icache_req/addr     - fetch request and address (= PC)
//                icache_ready/data   - fetched word valid for icache_addr
//                if_valid/instr/pc/pc_plus2 - IF/ID register contents
//                fetch_halted        - HLT delivered, fetch stopped
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_addr,
  input  logic        hazard_stall,
  output logic        icache_req,
  output logic [15:0] icache_addr,
  input  logic        icache_ready,
  input  logic [15:0] icache_data,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus2,
  output logic        fetch_halted
);

  fetch_state_e state;
  logic [15:0]  pc;
  logic [15:0]  pending_target;
  logic [15:0]  pc_plus2;
  logic         add_cout_unused;
  logic         add_ovf_unused;

  cla_16bit u_pc_adder (
    .a        (pc),
    .b        (PC_STEP),
    .cin      (1'b0),
    .sum      (pc_plus2),
    .cout     (add_cout_unused),
    .overflow (add_ovf_unused)
  );

  // The address stays on pc until the access completes, so a miss sees a
  // stable address for its whole duration.
  assign icache_req  = rst_n & (state != HALTED);
  assign icache_addr = pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= RUN;
      pc             <= RESET_PC;
      pending_target <= 16'h0000;
      if_valid       <= 1'b0;
      if_instr       <= FETCH_NOP;
      if_pc          <= 16'h0000;
      if_pc_plus2    <= 16'h0000;
      fetch_halted   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (redirect_valid) begin
            // Whatever arrives this cycle is on the wrong path.
            if_valid <= 1'b0;
            if_instr <= FETCH_NOP;
            if (icache_ready) begin
              pc <= redirect_addr;
            end else begin
              // Cannot abandon the outstanding miss; remember the target
              // and drop the data when it finally returns.
              pending_target <= redirect_addr;
              state          <= SQUASH;
            end
          end else if (hazard_stall) begin
            // Hold PC and IF/ID; the request stays asserted.
          end else if (!icache_ready) begin
            if_valid <= 1'b0;
            if_instr <= FETCH_NOP;
          end else begin
            if_valid    <= 1'b1;
            if_instr    <= icache_data;
            if_pc       <= pc;
            if_pc_plus2 <= pc_plus2;
            if (is_halt(icache_data)) begin
              state        <= HALTED;
              fetch_halted <= 1'b1;
            end else begin
              pc <= pc_plus2;
            end
          end
        end

        SQUASH: begin
          if_valid <= 1'b0;
          if_instr <= FETCH_NOP;
          if (icache_ready) begin
            // A redirect arriving on the completion cycle is the newest.
            pc    <= redirect_valid ? redirect_addr : pending_target;
            state <= RUN;
          end else if (redirect_valid) begin
            pending_target <= redirect_addr;
          end
        end

        HALTED: begin
          if (redirect_valid) begin
            // An older branch in ID overrides the HLT.
            pc           <= redirect_addr;
            if_valid     <= 1'b0;
            if_instr     <= FETCH_NOP;
            state        <= RUN;
            fetch_halted <= 1'b0;
          end else if (!hazard_stall) begin
            if_valid <= 1'b0;
            if_instr <= FETCH_NOP;
          end
        end

        default: begin
          state        <= RUN;
          fetch_halted <= 1'b0;
          if_valid     <= 1'b0;
          if_instr     <= FETCH_NOP;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
